// File: rtl/vga_timing_gen_pkg.sv
// Package vga_timing_pkg: default 640x480@60 Hz raster timing, pixel-clock
// divider default and the raster count width shared by the VGA timing slice.
package vga_timing_pkg;

   localparam int COUNT_W         = 10;   // hCount/vCount width

   localparam int CLK_DIV_DEF     = 4;    // 100 MHz -> 25 MHz pixel rate

   localparam int H_TOTAL_DEF     = 800;
   localparam int H_SYNC_DEF      = 96;
   localparam int H_ACT_START_DEF = 144;
   localparam int H_ACT_END_DEF   = 784;

   localparam int V_TOTAL_DEF     = 525;
   localparam int V_SYNC_DEF      = 2;
   localparam int V_ACT_START_DEF = 35;
   localparam int V_ACT_END_DEF   = 515;

endpackage

// File: rtl/vga_timing_gen_pix_clk_en.sv
// pix_clk_en: divides clk by CLK_DIV and produces the registered one-clk
// pix_en strobe.
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   tick     out  combinational: divider on its last count, so pix_en rises
//                 on the next edge; the raster counters advance on that edge
//   pix_en   out  registered strobe, high one clk in every CLK_DIV clks
module pix_clk_en #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic reset_n,
   output logic tick,
   output logic pix_en
);

   // A one-bit counter is kept for CLK_DIV==1; it simply stays at 0.
   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

   logic [DW-1:0] div;

   assign tick = (div == LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div    <= '0;
         pix_en <= 1'b0;
      end else begin
         div    <= tick ? '0 : div + DW'(1);
         pix_en <= tick;
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 Hz raster generator for the pixel painter.
//   clk          in   100 MHz system clock
//   reset_n      in   asynchronous active-low reset
//   pix_en       out  one-clk strobe every CLK_DIV clks
//   hCount       out  horizontal position 0..H_TOTAL-1
//   vCount       out  vertical position 0..V_TOTAL-1
//   hSync/vSync  out  active-low syncs
//   bright       out  active-video flag
//   line_start   out  one-clk pulse when hCount becomes 0
//   frame_start  out  one-clk pulse when (hCount,vCount) becomes (0,0)
// All outputs are registered and update on the same edge as pix_en rises,
// so the syncs and bright have zero skew against the counts.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int CLK_DIV     = CLK_DIV_DEF,
   parameter int H_TOTAL     = H_TOTAL_DEF,
   parameter int H_SYNC      = H_SYNC_DEF,
   parameter int H_ACT_START = H_ACT_START_DEF,
   parameter int H_ACT_END   = H_ACT_END_DEF,
   parameter int V_TOTAL     = V_TOTAL_DEF,
   parameter int V_SYNC      = V_SYNC_DEF,
   parameter int V_ACT_START = V_ACT_START_DEF,
   parameter int V_ACT_END   = V_ACT_END_DEF
) (
   input  logic               clk,
   input  logic               reset_n,
   output logic               pix_en,
   output logic [COUNT_W-1:0] hCount,
   output logic [COUNT_W-1:0] vCount,
   output logic               hSync,
   output logic               vSync,
   output logic               bright,
   output logic               line_start,
   output logic               frame_start
);

   logic               tick;
   logic [COUNT_W-1:0] h_nxt;
   logic [COUNT_W-1:0] v_nxt;

   pix_clk_en #(.CLK_DIV(CLK_DIV)) u_pix_clk_en (
      .clk     (clk),
      .reset_n (reset_n),
      .tick    (tick),
      .pix_en  (pix_en)
   );

   always_comb begin
      h_nxt = hCount + COUNT_W'(1);
      v_nxt = vCount;
      if (hCount == COUNT_W'(H_TOTAL - 1)) begin
         h_nxt = '0;
         v_nxt = (vCount == COUNT_W'(V_TOTAL - 1)) ? '0 : vCount + COUNT_W'(1);
      end
   end

   // Decode is taken from the next counts so the registered syncs, bright
   // and strobes land on the same edge as the counts they describe.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hCount      <= COUNT_W'(H_TOTAL - 1);
         vCount      <= COUNT_W'(V_TOTAL - 1);
         hSync       <= 1'b1;
         vSync       <= 1'b1;
         bright      <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else if (tick) begin
         hCount      <= h_nxt;
         vCount      <= v_nxt;
         hSync       <= (h_nxt >= COUNT_W'(H_SYNC));
         vSync       <= (v_nxt >= COUNT_W'(V_SYNC));
         bright      <= (h_nxt >= COUNT_W'(H_ACT_START)) && (h_nxt < COUNT_W'(H_ACT_END)) &&
                        (v_nxt >= COUNT_W'(V_ACT_START)) && (v_nxt < COUNT_W'(V_ACT_END));
         line_start  <= (h_nxt == '0);
         frame_start <= (h_nxt == '0) && (v_nxt == '0);
      end else begin
         // Strobes last one clk even when CLK_DIV > 1.
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen. Instance a uses the default timing;
// instance b uses CLK_DIV=1 with a tiny raster so whole frames, vertical
// wrap and the bright window fit in a short run.
module tb_vga_timing_gen;
   import vga_timing_pkg::*;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   logic         a_pix, a_hs, a_vs, a_br, a_ls, a_fs;
   logic [9:0]   a_h, a_v;
   logic         b_pix, b_hs, b_vs, b_br, b_ls, b_fs;
   logic [9:0]   b_h, b_v;

   vga_timing_gen u_a (
      .clk(clk), .reset_n(reset_n), .pix_en(a_pix), .hCount(a_h), .vCount(a_v),
      .hSync(a_hs), .vSync(a_vs), .bright(a_br), .line_start(a_ls), .frame_start(a_fs)
   );

   vga_timing_gen #(
      .CLK_DIV(1), .H_TOTAL(20), .H_SYNC(3), .H_ACT_START(5), .H_ACT_END(15),
      .V_TOTAL(12), .V_SYNC(2), .V_ACT_START(4), .V_ACT_END(10)
   ) u_b (
      .clk(clk), .reset_n(reset_n), .pix_en(b_pix), .hCount(b_h), .vCount(b_v),
      .hSync(b_hs), .vSync(b_vs), .bright(b_br), .line_start(b_ls), .frame_start(b_fs)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int a_last_pix = -1;
   int a_last_ls = -1;
   int b_last_fs = -1;
   bit b_run = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One clk; sample on the falling edge and run the per-cycle checks.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
      cyc++;
      chk("a_hsync_dec", a_hs, 32'(a_h >= 10'd96));
      chk("a_vsync_dec", a_vs, 32'(a_v >= 10'd2));
      chk("a_bright_dec", a_br, 32'(a_h >= 10'd144 && a_h < 10'd784 && a_v >= 10'd35 && a_v < 10'd515));
      chk("a_h_range", 32'(a_h < 10'd800), 1);
      chk("a_v_range", 32'(a_v < 10'd525), 1);
      chk("b_hsync_dec", b_hs, 32'(b_h >= 10'd3));
      chk("b_vsync_dec", b_vs, 32'(b_v >= 10'd2));
      chk("b_bright_dec", b_br, 32'(b_h >= 10'd5 && b_h < 10'd15 && b_v >= 10'd4 && b_v < 10'd10));
      chk("b_v_range", 32'(b_v < 10'd12), 1);
      if (!reset_n) begin
         a_last_pix = -1;
         a_last_ls = -1;
         b_last_fs = -1;
         b_run = 1'b0;
      end else begin
         if (a_pix) begin
            if (a_last_pix >= 0) chk("a_pix_period", cyc - a_last_pix, 4);
            a_last_pix = cyc;
         end
         if (a_ls) begin
            chk("a_ls_h0", a_h, 0);
            if (a_last_ls >= 0) chk("a_line_len", cyc - a_last_ls, 3200);
            a_last_ls = cyc;
         end
         if (a_fs) chk("a_fs_implies_ls", a_ls, 1);
         if (b_run) chk("b_pix_const", b_pix, 1);
         if (b_fs) begin
            chk("b_fs_ls", b_ls, 1);
            chk("b_fs_h0", b_h, 0);
            chk("b_fs_v0", b_v, 0);
            if (b_last_fs >= 0) chk("b_frame_period", cyc - b_last_fs, 240);
            b_last_fs = cyc;
         end
      end
   endtask

   task automatic wait_a(input int h, input int v);
      int n = 0;
      while (!(a_pix && a_h == 10'(h) && a_v == 10'(v)) && n < 20000) begin
         step();
         n++;
      end
      chk("a_reach", 32'(n < 20000), 1);
   endtask

   task automatic wait_b(input int h, input int v);
      int n = 0;
      while (!(b_h == 10'(h) && b_v == 10'(v)) && n < 500) begin
         step();
         n++;
      end
      chk("b_reach", 32'(n < 500), 1);
   endtask

   task automatic chk_reset_vals();
      chk("rst_a_pix", a_pix, 0);
      chk("rst_a_h", a_h, 799);
      chk("rst_a_v", a_v, 524);
      chk("rst_a_hs", a_hs, 1);
      chk("rst_a_vs", a_vs, 1);
      chk("rst_a_br", a_br, 0);
      chk("rst_a_ls", a_ls, 0);
      chk("rst_a_fs", a_fs, 0);
      chk("rst_b_h", b_h, 19);
      chk("rst_b_v", b_v, 11);
      chk("rst_b_pix", b_pix, 0);
   endtask

   // Release reset on a falling edge and check the start-up sequence.
   task automatic release_seq();
      reset_n = 1'b1;
      b_run = 1'b1;
      step();
      chk("b_first_pix", b_pix, 1);
      chk("b_first_h", b_h, 0);
      chk("b_first_fs", b_fs, 1);
      chk("a_c1_pix", a_pix, 0);
      chk("a_c1_h", a_h, 799);
      step();
      chk("b_c2_fs", b_fs, 0);
      chk("b_c2_h", b_h, 1);
      step();
      chk("a_c3_pix", a_pix, 0);
      chk("a_c3_v", a_v, 524);
      chk("a_c3_fs", a_fs, 0);
      step();
      chk("a_c4_pix", a_pix, 1);
      chk("a_c4_h", a_h, 0);
      chk("a_c4_v", a_v, 0);
      chk("a_c4_fs", a_fs, 1);
      chk("a_c4_ls", a_ls, 1);
      chk("a_c4_hs", a_hs, 0);
      chk("a_c4_vs", a_vs, 0);
      step();
      chk("a_c5_pix", a_pix, 0);
      chk("a_c5_fs", a_fs, 0);
      chk("a_c5_ls", a_ls, 0);
      chk("a_c5_h", a_h, 0);
   endtask

   initial begin
      // Reset held 10 clks, then start-up sequence.
      repeat (10) step();
      chk_reset_vals();
      release_seq();

      // hSync edges on the first line, then vSync across lines 0..2.
      wait_a(1, 0);
      chk("a_h1_pix_period_ls", a_ls, 0);
      wait_a(95, 0);
      chk("a_hs_95", a_hs, 0);
      wait_a(96, 0);
      chk("a_hs_96", a_hs, 1);
      wait_a(799, 0);
      chk("a_hs_799", a_hs, 1);
      wait_a(0, 1);
      chk("a_ls_line1", a_ls, 1);
      chk("a_fs_line1", a_fs, 0);
      chk("a_vs_line1", a_vs, 0);
      wait_a(799, 1);
      chk("a_vs_799_1", a_vs, 0);
      wait_a(0, 2);
      chk("a_vs_line2", a_vs, 1);
      wait_a(144, 2);
      chk("a_br_144_2", a_br, 0);

      // Small raster: bright window edges, vertical sync, full wrap.
      wait_b(5, 3);
      chk("b_br_5_3", b_br, 0);
      wait_b(4, 4);
      chk("b_br_4_4", b_br, 0);
      wait_b(5, 4);
      chk("b_br_5_4", b_br, 1);
      wait_b(14, 4);
      chk("b_br_14_4", b_br, 1);
      wait_b(15, 4);
      chk("b_br_15_4", b_br, 0);
      wait_b(5, 9);
      chk("b_br_5_9", b_br, 1);
      wait_b(5, 10);
      chk("b_br_5_10", b_br, 0);
      wait_b(19, 11);
      step();
      chk("b_wrap_h", b_h, 0);
      chk("b_wrap_v", b_v, 0);
      chk("b_wrap_fs", b_fs, 1);
      wait_b(0, 1);
      chk("b_vs_1", b_vs, 0);
      wait_b(0, 2);
      chk("b_vs_2", b_vs, 1);

      // Mid-clock asynchronous reset aborts the frame immediately.
      wait_a(400, 2);
      #2;
      reset_n = 1'b0;
      #1;
      chk_reset_vals();
      repeat (3) step();
      chk_reset_vals();
      release_seq();
      repeat (20) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
